// File: rtl/irq_ctrl.sv
// irq_ctrl -- memory-mapped interrupt controller for a single-trap CPU.
//
// Latches rising edges of up to 16 synchronous sources into PENDING, masks
// them with ENABLE, and raises a one-cycle `interrupt` for the lowest-index
// enabled request. Further interrupts are held off until software writes
// COMPLETE.
//
// Ports:
//   clk, rst       : clock (rising edge), synchronous active-high reset
//   irq_src        : interrupt sources, rising edge = request
//   dbus_addr      : CPU data byte address
//   dbus_write     : CPU write data
//   dbus_wen       : CPU write strobe
//   dbus_read      : registered read data, valid one cycle after the address
//   dbus_rsel      : registered, marks dbus_read as driven by this block
//   interrupt      : one-cycle trap request
//   irq_id         : id of the in-service source (valid while active)
//
// Register map (offsets from BASE_ADDR):
//   0x0 PENDING  (W1C)   0x4 ENABLE (RW)
//   0x8 CLAIM    (RO, {active, 27'b0, irq_id})   0xC COMPLETE (WO, reads 0)
module irq_ctrl #(
  parameter int          N_SRC     = 8,
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [15:0]      dbus_addr,
  input  logic [31:0]      dbus_write,
  input  logic             dbus_wen,
  output logic [31:0]      dbus_read,
  output logic             dbus_rsel,
  output logic             interrupt,
  output logic [3:0]       irq_id
);

  typedef enum logic [1:0] {IDLE, FIRE, SERVICE} state_t;

  state_t           state;
  logic [N_SRC-1:0] src_d;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] enable;
  logic [N_SRC-1:0] pending_nxt;
  logic [N_SRC-1:0] edge_det;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] grant;
  logic [3:0]       sel;
  logic             any_req;
  logic             active;
  logic             hit;
  logic [3:0]       ofs;
  logic             wr_pend;
  logic             wr_en;
  logic             wr_cmpl;
  logic             rd_hit;
  logic [31:0]      rd_data;
  logic             unused_wdata;

  // Index of the lowest set bit (lowest index has highest priority).
  function automatic logic [3:0] prio_sel(input logic [N_SRC-1:0] r);
    logic [3:0] enc;
    enc = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (r[i]) enc = 4'(i);
    end
    return enc;
  endfunction

  // One-hot mask of the lowest set bit, used to clear the granted pending bit.
  function automatic logic [N_SRC-1:0] prio_grant(input logic [N_SRC-1:0] r);
    return r & (~r + N_SRC'(1));
  endfunction

  assign hit     = (dbus_addr[15:4] == BASE_ADDR[15:4]);
  assign ofs     = dbus_addr[3:0];
  assign wr_pend = hit && dbus_wen && (ofs == 4'h0);
  assign wr_en   = hit && dbus_wen && (ofs == 4'h4);
  assign wr_cmpl = hit && dbus_wen && (ofs == 4'hC);
  assign rd_hit  = hit && !dbus_wen;

  // Upper write-data bits have no destination when N_SRC < 32.
  assign unused_wdata = ^dbus_write;

  assign edge_det = irq_src & ~src_d;
  assign req      = pending & enable;
  assign any_req  = |req;
  assign sel      = prio_sel(req);
  assign grant    = prio_grant(req);
  assign active   = (state != IDLE);

  // Order matters: W1C first, then the grant clear, then new edges, so an
  // edge always wins over a clear on the same bit in the same cycle.
  always_comb begin
    pending_nxt = pending;
    if (wr_pend) pending_nxt = pending_nxt & ~dbus_write[N_SRC-1:0];
    if (state == IDLE && any_req) pending_nxt = pending_nxt & ~grant;
    pending_nxt = pending_nxt | edge_det;
  end

  always_comb begin
    rd_data = '0;
    case (ofs)
      4'h0:    rd_data[N_SRC-1:0] = pending;
      4'h4:    rd_data[N_SRC-1:0] = enable;
      4'h8:    rd_data = {active, 27'b0, irq_id};
      default: rd_data = '0;
    endcase
  end

  // Register stage: edge history, pending/enable, FSM and read-back port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      src_d     <= '0;
      pending   <= '0;
      enable    <= '0;
      irq_id    <= '0;
      interrupt <= 1'b0;
      dbus_read <= '0;
      dbus_rsel <= 1'b0;
    end else begin
      src_d     <= irq_src;
      pending   <= pending_nxt;
      if (wr_en) enable <= dbus_write[N_SRC-1:0];
      dbus_rsel <= rd_hit;
      dbus_read <= rd_hit ? rd_data : '0;
      interrupt <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= FIRE;
            irq_id    <= sel;
            interrupt <= 1'b1;
          end
        end
        FIRE: state <= SERVICE;
        SERVICE: begin
          // irq_id is zeroed on completion so CLAIM reads 0 when idle.
          if (wr_cmpl) begin
            state  <= IDLE;
            irq_id <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
